// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the 4-bit CPU and its program loader.
//   - Instruction store geometry (DEPTH, ADDR_W, MAX_BYTES).
//   - Loader FSM state encodings (localparam constants).
//   - Opcode nibble values.
//   - addr_inc(): nibble-address increment with wrap modulo DEPTH.
package cpu_pkg;

    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int MAX_BYTES = DEPTH / 2;

    // Loader states
    typedef logic [2:0] ld_state_t;
    localparam ld_state_t ST_IDLE  = 3'd0;
    localparam ld_state_t ST_LOAD  = 3'd1;
    localparam ld_state_t ST_CHECK = 3'd2;
    localparam ld_state_t ST_RUN   = 3'd3;
    localparam ld_state_t ST_ERROR = 3'd4;

    // Opcodes (high nibble of a fetched byte is the operand, low is the opcode)
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOAD     = 4'd1;
    localparam logic [3:0] OP_ADD      = 4'd2;
    localparam logic [3:0] OP_SUB      = 4'd3;
    localparam logic [3:0] OP_AND      = 4'd4;
    localparam logic [3:0] OP_OR       = 4'd5;
    localparam logic [3:0] OP_STORE    = 4'd6;
    localparam logic [3:0] OP_XNOR_JMP = 4'd7;

    // Next nibble address; the natural ADDR_W-bit overflow gives the wrap.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/imem_nibble_ram.sv
// imem_nibble_ram: DEPTH x 4-bit instruction store.
//   clk, reset  : clock, async active-high reset (clears every word)
//   clear       : synchronous clear of every word (has priority over we)
//   we, waddr   : write wdata[3:0] to waddr and wdata[7:4] to waddr+1
//   wdata       : byte to unpack
//   raddr       : combinational read address
//   rdata       : {mem[raddr+1], mem[raddr]}, upper address wraps
module imem_nibble_ram
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [DEPTH-1:0][3:0] mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else if (clear) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr]           <= wdata[3:0];
            mem[addr_inc(waddr)] <= wdata[7:4];
        end
    end

    assign rdata = {mem[addr_inc(raddr)], mem[raddr]};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader and instruction store for the
// 4-bit CPU. Each instruction byte becomes two nibble words (opcode at the
// even address, operand at the odd one); a trailing XOR checksum byte
// (s_last) ends the stream and is verified before the CPU is released.
//   clk, reset  : clock, async active-high reset
//   start       : pulse; begins a new load from IDLE, RUN or ERROR
//   s_valid, s_data, s_last, s_ready : byte stream handshake
//   fetch_addr, fetch_data : CPU fetch port, NOP (8'h00) unless running
//   cpu_hold    : CPU reset, low only while running
//   load_done   : program verified and running
//   load_err    : checksum mismatch or overflow
//   byte_count  : instruction bytes accepted in the current/last load
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [3:0]        byte_count
);

    ld_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        acc;
    logic [3:0]        cnt;
    logic              sum_ok;

    logic              hs;
    logic              full;
    logic              clear;
    logic              wr_en;
    logic [7:0]        ram_rdata;

    assign s_ready = (state == ST_LOAD);
    assign hs      = s_valid && s_ready;
    assign full    = (cnt == 4'(MAX_BYTES));
    // start only matters outside LOAD/CHECK; it wipes the store for the new load.
    assign clear   = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
    assign wr_en   = hs && !s_last && !full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            acc    <= 8'h00;
            cnt    <= 4'd0;
            sum_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (start) begin
                        state <= ST_LOAD;
                        ptr   <= '0;
                        acc   <= 8'h00;
                        cnt   <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        if (s_last) begin
                            sum_ok <= (acc == s_data);
                            state  <= ST_CHECK;
                        end else if (full) begin
                            state <= ST_ERROR;
                        end else begin
                            // After the last legal byte ptr wraps back to 0.
                            ptr <= ptr + ADDR_W'(2);
                            acc <= acc ^ s_data;
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_CHECK: state <= sum_ok ? ST_RUN : ST_ERROR;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    imem_nibble_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .we    (wr_en),
        .waddr (ptr),
        .wdata (s_data),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    assign cpu_hold   = (state != ST_RUN);
    assign load_done  = (state == ST_RUN);
    assign load_err   = (state == ST_ERROR);
    assign byte_count = cnt;
    assign fetch_data = load_done ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized bench for prog_loader with a behavioural model
// (program kept as a byte queue, checksum recomputed from the queue) and a
// negedge compare process, plus literal expectations for the directed cases.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [3:0] byte_count;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MI = 0, ML = 1, MC = 2, MR = 3, ME = 4;
    int         m_mode;
    logic [3:0] m_mem [16];
    logic [7:0] m_prog [$];
    bit         m_ok;

    function automatic logic [7:0] q_xor();
        logic [7:0] x = 8'h00;
        foreach (m_prog[i]) x ^= m_prog[i];
        return x;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = MI;
            m_prog.delete();
            foreach (m_mem[i]) m_mem[i] = 4'h0;
        end else begin
            case (m_mode)
                ML: begin
                    if (s_valid) begin
                        if (s_last) begin
                            m_ok   = (q_xor() == s_data);
                            m_mode = MC;
                        end else if (m_prog.size() == 8) begin
                            m_mode = ME;
                        end else begin
                            m_mem[2*m_prog.size()]   = s_data[3:0];
                            m_mem[2*m_prog.size()+1] = s_data[7:4];
                            m_prog.push_back(s_data);
                        end
                    end
                end
                MC: m_mode = m_ok ? MR : ME;
                default: begin
                    if (start) begin
                        m_mode = ML;
                        m_prog.delete();
                        foreach (m_mem[i]) m_mem[i] = 4'h0;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int a;
            logic [7:0] ef;
            a  = int'(fetch_addr);
            ef = (m_mode == MR) ? {m_mem[(a+1)%16], m_mem[a]} : 8'h00;
            chk("s_ready",    {7'b0, s_ready},   {7'b0, m_mode == ML});
            chk("cpu_hold",   {7'b0, cpu_hold},  {7'b0, m_mode != MR});
            chk("load_done",  {7'b0, load_done}, {7'b0, m_mode == MR});
            chk("load_err",   {7'b0, load_err},  {7'b0, m_mode == ME});
            chk("byte_count", {4'b0, byte_count}, 8'(m_prog.size()));
            chk("fetch_data", fetch_data, ef);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        fetch_addr = 4'($urandom_range(0, 15));
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string nm);
        fetch_addr = a;
        #1;
        chk(nm, fetch_data, exp);
    endtask

    task automatic good_stream();
        send(8'h51, 1'b0);
        send(8'h06, 1'b0);
        send(8'h12, 1'b0);
        send(8'h45, 1'b1);
        cyc();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; s_valid = 1'b0;
        s_data = 8'h00; s_last = 1'b0; fetch_addr = 4'h0;
        #1 reset = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b1;
        #1;
        chk("rst_hold",  {7'b0, cpu_hold},  8'h01);
        chk("rst_ready", {7'b0, s_ready},   8'h00);
        chk("rst_done",  {7'b0, load_done}, 8'h00);
        chk("rst_err",   {7'b0, load_err},  8'h00);
        chk("rst_count", {4'b0, byte_count}, 8'h00);
        reset = 1'b0;

        // Basic load: three bytes plus checksum 0x45
        do_start();
        send(8'h51, 1'b0);
        send(8'h06, 1'b0);
        send(8'h12, 1'b0);
        send(8'h45, 1'b1);
        chk("check_not_done", {7'b0, load_done}, 8'h00);
        cyc();
        chk("lit_done", {7'b0, load_done}, 8'h01);
        chk("lit_hold", {7'b0, cpu_hold},  8'h00);
        chk("lit_count", {4'b0, byte_count}, 8'h03);
        peek(4'd0, 8'h51, "lit_fetch0");
        peek(4'd2, 8'h06, "lit_fetch2");
        peek(4'd4, 8'h12, "lit_fetch4");
        peek(4'd1, 8'h65, "lit_fetch1");

        // Bad checksum, then recovery
        do_start();
        send(8'h51, 1'b0);
        send(8'h06, 1'b0);
        send(8'h12, 1'b0);
        send(8'h44, 1'b1);
        cyc();
        chk("bad_err",  {7'b0, load_err}, 8'h01);
        chk("bad_hold", {7'b0, cpu_hold}, 8'h01);
        peek(4'd0, 8'h00, "bad_fetch0");
        peek(4'd5, 8'h00, "bad_fetch5");
        do_start();
        good_stream();
        chk("recover_done", {7'b0, load_done}, 8'h01);

        // Overflow: nine instruction bytes
        do_start();
        for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), 1'b0);
        chk("ovf_err",   {7'b0, load_err}, 8'h01);
        chk("ovf_count", {4'b0, byte_count}, 8'h08);

        // Maximum program: eight 0xFF, checksum 0x00
        do_start();
        for (int i = 0; i < 8; i++) send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        cyc();
        chk("max_done", {7'b0, load_done}, 8'h01);
        peek(4'd15, 8'hFF, "max_fetch15");

        // Gapped valid with a start pulse mid-load, then reset mid-load
        do_start();
        send(8'h3C, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        send(8'hA5, 1'b0);
        chk("gap_count", {4'b0, byte_count}, 8'h02);
        chk("gap_ready", {7'b0, s_ready}, 8'h01);
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("midrst_hold",  {7'b0, cpu_hold}, 8'h01);
        chk("midrst_count", {4'b0, byte_count}, 8'h00);
        chk("midrst_ready", {7'b0, s_ready}, 8'h00);
        cyc();
        chk("rst_beats_start", {7'b0, s_ready}, 8'h00);
        reset = 1'b0;
        start = 1'b0;

        // Restart from RUN, then empty program
        do_start();
        good_stream();
        do_start();
        chk("rerun_hold", {7'b0, cpu_hold},  8'h01);
        chk("rerun_done", {7'b0, load_done}, 8'h00);
        peek(4'd0, 8'h00, "rerun_fetch0");
        send(8'h00, 1'b1);
        cyc();
        chk("empty_done",  {7'b0, load_done}, 8'h01);
        chk("empty_count", {4'b0, byte_count}, 8'h00);
        for (int a = 0; a < 16; a++) peek(4'(a), 8'h00, "empty_fetch");
        do_start();
        send(8'h01, 1'b1);
        cyc();
        chk("empty_bad_err", {7'b0, load_err}, 8'h01);

        // Randomized loads
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end
            do_start();
            begin
                int n;
                logic [7:0] x;
                logic [7:0] d;
                n = $urandom_range(0, 9);
                x = 8'h00;
                for (int i = 0; i < n; i++) begin
                    while ($urandom_range(0, 2) == 0) begin
                        start  = 1'($urandom_range(0, 1));
                        s_data = 8'($urandom_range(0, 255));
                        cyc();
                        start  = 1'b0;
                    end
                    d = 8'($urandom_range(0, 255));
                    x ^= d;
                    send(d, 1'b0);
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                send(x, 1'b1);
            end
            for (int k = 0; k < 4; k++) begin
                s_valid = 1'($urandom_range(0, 1));
                s_last  = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom_range(0, 255));
                cyc();
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
        end

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
